cmd_executor: RTL and testbench

Executes memory-access commands produced by `cmd_parser`, one at a time. It sits downstream of the command FIFO, which `cmd_parser` fills with `cmd_packet_t` entries. For each command it drives a synchronous single-port memory. It then writes response bytes into the TX byte FIFO that feeds the UART transmitter, closing the RX → parse → execute → TX loop.

---
 rtl/cmd_executor_if.sv | 41 ++++
 rtl/cmd_executor.sv | 154 +++++++++++++++
 tb/tb_cmd_executor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_executor_if.sv
// Command packet type and the bundled command-FIFO / memory / TX-FIFO port
// set seen by cmd_executor (master side) and its environment (slave side).
package cmd_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  data;
  } cmd_packet_t;
endpackage

interface cmd_executor_if #(
  parameter int ADDR_W = 10
);
  import cmd_pkg::*;

  logic              cmd_fifo_valid;
  cmd_packet_t       cmd_fifo_rd_data;
  logic              cmd_fifo_rd_en;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              tx_fifo_full;
  logic              tx_fifo_wr_en;
  logic [7:0]        tx_fifo_wr_data;
  logic              busy;

  modport master (
    input  cmd_fifo_valid, cmd_fifo_rd_data, mem_rdata, tx_fifo_full,
    output cmd_fifo_rd_en, mem_en, mem_we, mem_addr, mem_wdata,
           tx_fifo_wr_en, tx_fifo_wr_data, busy
  );

  modport slave (
    output cmd_fifo_valid, cmd_fifo_rd_data, mem_rdata, tx_fifo_full,
    input  cmd_fifo_rd_en, mem_en, mem_we, mem_addr, mem_wdata,
           tx_fifo_wr_en, tx_fifo_wr_data, busy
  );
endinterface

// File: rtl/cmd_executor.sv
// Executes one W/R command at a time against a single-port memory and pushes
// the response bytes into the TX FIFO. All outputs come from registers.
module cmd_executor
  import cmd_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  cmd_executor_if.master bus
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RD_SEND,
    RESP
  } state_t;

  state_t            state;
  cmd_packet_t       cmd;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        remain;
  logic              rd_en;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              wr_en;
  logic [7:0]        wr_data;

  function automatic logic addr_in_range(input logic [15:0] a);
    return (a >> ADDR_W) == 16'd0;
  endfunction

  function automatic logic cmd_is_error(input cmd_packet_t c);
    return !addr_in_range(c.addr) || ((c.opcode != OP_WRITE) && (c.opcode != OP_READ));
  endfunction

  // wr_en is registered, so the decision to push in a cycle is taken from
  // tx_fifo_full as sampled at the preceding edge. A push cycle always ends
  // the SEND/RESP state; the next command may be latched on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en) begin
            rd_en <= 1'b0;
            state <= DECODE;
          end else if (bus.cmd_fifo_valid) begin
            cmd   <= bus.cmd_fifo_rd_data;
            rd_en <= 1'b1;
          end
        end
        DECODE: begin
          if (cmd_is_error(cmd)) begin
            wr_data <= RESP_ERR;
            wr_en   <= !bus.tx_fifo_full;
            state   <= RESP;
          end else if (cmd.opcode == OP_WRITE) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cmd.addr[ADDR_W-1:0];
            mem_wdata <= cmd.data;
            state     <= WRITE;
          end else begin
            cur_addr <= cmd.addr[ADDR_W-1:0];
            remain   <= cmd.len;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cmd.addr[ADDR_W-1:0];
            state    <= RD_REQ;
          end
        end
        WRITE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          wr_data <= RESP_OK;
          wr_en   <= !bus.tx_fifo_full;
          state   <= RESP;
        end
        RD_REQ: begin
          mem_en <= 1'b0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          wr_data <= bus.mem_rdata;
          wr_en   <= !bus.tx_fifo_full;
          state   <= RD_SEND;
        end
        RD_SEND: begin
          if (wr_en) begin
            wr_en <= 1'b0;
            if (remain == 8'd0) begin
              state <= IDLE;
              if (bus.cmd_fifo_valid) begin
                cmd   <= bus.cmd_fifo_rd_data;
                rd_en <= 1'b1;
              end
            end else begin
              cur_addr <= cur_addr + 1'b1;
              remain   <= remain - 8'd1;
              mem_en   <= 1'b1;
              mem_addr <= cur_addr + 1'b1;
              state    <= RD_REQ;
            end
          end else begin
            wr_en <= !bus.tx_fifo_full;
          end
        end
        RESP: begin
          if (wr_en) begin
            wr_en <= 1'b0;
            state <= IDLE;
            if (bus.cmd_fifo_valid) begin
              cmd   <= bus.cmd_fifo_rd_data;
              rd_en <= 1'b1;
            end
          end else begin
            wr_en <= !bus.tx_fifo_full;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_fifo_rd_en  = rd_en;
  assign bus.mem_en          = mem_en;
  assign bus.mem_we          = mem_we;
  assign bus.mem_addr        = mem_addr;
  assign bus.mem_wdata       = mem_wdata;
  assign bus.tx_fifo_wr_en   = wr_en;
  assign bus.tx_fifo_wr_data = wr_data;
  assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_cmd_executor.sv
// Bench for cmd_executor: directed vector table, hand-written multi-cycle
// sequences, and a randomized command stream checked against a memory model.
module tb_cmd_executor;
  import cmd_pkg::*;

  localparam int ADDR_W = 10;
  localparam logic [7:0] W = 8'h57, R = 8'h52, K = 8'h4B, E = 8'h45;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_full = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_executor_if #(.ADDR_W(ADDR_W)) bus ();
  cmd_executor #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Show-ahead command FIFO: main process appends, this process owns the head.
  cmd_packet_t cmd_q[$];
  int          head = 0;
  logic        fifo_valid = 1'b0;
  cmd_packet_t fifo_data = '0;
  logic        pop;
  assign bus.cmd_fifo_valid   = fifo_valid;
  assign bus.cmd_fifo_rd_data = fifo_data;
  always begin
    @(negedge clk);
    pop = bus.cmd_fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop) head = head + 1;
    fifo_valid = (head < cmd_q.size());
    fifo_data  = fifo_valid ? cmd_q[head] : '0;
  end

  // Synchronous single-port memory.
  logic [7:0] sim_mem [1<<ADDR_W];
  logic [7:0] rdata_r = 8'h00;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) sim_mem[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_r <= sim_mem[bus.mem_addr];
    end
  assign bus.mem_rdata    = rdata_r;
  assign bus.tx_fifo_full = tx_full;

  // Event logs, sampled mid-cycle.
  int         rden_t[$];
  int         mem_t[$];
  logic [18:0] mem_e[$];
  int         push_t[$];
  logic [7:0] push_d[$];
  int         full_viol = 0;
  always @(negedge clk) begin
    if (bus.cmd_fifo_rd_en) rden_t.push_back(cyc);
    if (bus.mem_en) begin
      mem_t.push_back(cyc);
      mem_e.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
    end
    if (bus.tx_fifo_wr_en) begin
      push_t.push_back(cyc);
      push_d.push_back(bus.tx_fifo_wr_data);
      if (bus.tx_fifo_full) full_viol = full_viol + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    cmd_packet_t cmd;
    logic [2:0]  nb;
    logic [31:0] b;
    logic [7:0]  first_t;
    logic [7:0]  last_t;
    logic [2:0]  n_mem;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [15:0] a, input logic [7:0] l,
                              input logic [7:0] d, input int nb, input logic [31:0] b,
                              input int ft, input int lt, input int nm);
    vec_t v;
    v.cmd.opcode = op;
    v.cmd.addr   = a;
    v.cmd.len    = l;
    v.cmd.data   = d;
    v.nb         = 3'(nb);
    v.b          = b;
    v.first_t    = 8'(ft);
    v.last_t     = 8'(lt);
    v.n_mem      = 3'(nm);
    return v;
  endfunction

  // Runs one command; tx_full is held high for cycles T(fs)..T(fs+fl-1).
  task automatic run_cmd(input vec_t v, input int fs, input int fl, input string tag);
    int p0, m0, r0, t0;
    bit done;
    p0 = push_t.size(); m0 = mem_t.size(); r0 = rden_t.size();
    t0 = -1; done = 1'b0;
    cmd_q.push_back(v.cmd);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (t0 < 0 && rden_t.size() > r0) t0 = rden_t[r0];
      if (t0 >= 0) begin
        tx_full = (fs >= 0) && (cyc >= t0 + fs) && (cyc < t0 + fs + fl);
        if (cyc > t0 + 1 && !bus.busy) done = 1'b1;
      end
    end
    tx_full = 1'b0;
    check({tag, " completes"}, done, 1);
    if (!done) return;
    check({tag, " byte count"}, push_t.size() - p0, v.nb);
    for (int k = 0; k < v.nb && p0 + k < push_t.size(); k++)
      check({tag, " byte"}, push_d[p0 + k], v.b[8*k +: 8]);
    if (v.nb > 0 && push_t.size() > p0) begin
      check({tag, " first push T"}, push_t[p0] - t0, v.first_t);
      check({tag, " last push T"}, push_t[push_t.size() - 1] - t0, v.last_t);
    end
    check({tag, " mem_en count"}, mem_t.size() - m0, v.n_mem);
    if (v.n_mem > 0 && mem_t.size() > m0) begin
      check({tag, " mem_en T"}, mem_t[m0] - t0, 2);
      check({tag, " mem_we"}, mem_e[m0][18], (v.cmd.opcode == W));
      check({tag, " mem_addr"}, mem_e[m0][17:8], v.cmd.addr[9:0]);
      if (v.cmd.opcode == W) check({tag, " mem_wdata"}, mem_e[m0][7:0], v.cmd.data);
    end
  endtask

  vec_t       vecs[14];
  logic [7:0] ref_mem [1<<ADDR_W];
  logic [7:0] exp_q[$];

  initial begin
    int p0, r0, t0;
    bit done;

    vecs[0]  = mk(W, 16'h0010, 8'd0, 8'hA5, 1, 32'h4B, 3, 3, 1);
    vecs[1]  = mk(W, 16'h03FE, 8'd0, 8'h11, 1, 32'h4B, 3, 3, 1);
    vecs[2]  = mk(W, 16'h03FF, 8'd0, 8'h22, 1, 32'h4B, 3, 3, 1);
    vecs[3]  = mk(W, 16'h0000, 8'd0, 8'h33, 1, 32'h4B, 3, 3, 1);
    vecs[4]  = mk(R, 16'h03FE, 8'd2, 8'h00, 3, 32'h00332211, 4, 10, 3);
    vecs[5]  = mk(W, 16'h0400, 8'd0, 8'h77, 1, 32'h45, 2, 2, 0);
    vecs[6]  = mk(8'h5A, 16'h0010, 8'd0, 8'h00, 1, 32'h45, 2, 2, 0);
    vecs[7]  = mk(R, 16'h8010, 8'd1, 8'h00, 1, 32'h45, 2, 2, 0);
    vecs[8]  = mk(R, 16'h0010, 8'd0, 8'h00, 1, 32'hA5, 4, 4, 1);
    vecs[9]  = mk(W, 16'h0100, 8'd0, 8'hC0, 1, 32'h4B, 3, 3, 1);
    vecs[10] = mk(W, 16'h0101, 8'd0, 8'hC1, 1, 32'h4B, 3, 3, 1);
    vecs[11] = mk(W, 16'h0102, 8'd0, 8'hC2, 1, 32'h4B, 3, 3, 1);
    vecs[12] = mk(W, 16'h0103, 8'd0, 8'hC3, 1, 32'h4B, 3, 3, 1);
    vecs[13] = mk(R, 16'h0010, 8'd0, 8'h00, 1, 32'hA5, 4, 4, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cmd_fifo_rd_en", bus.cmd_fifo_rd_en, 0);
    check("reset mem_en", bus.mem_en, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    check("reset tx_fifo_wr_en", bus.tx_fifo_wr_en, 0);
    check("reset tx_fifo_wr_data", bus.tx_fifo_wr_data, 0);
    check("reset busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_cmd(vecs[i], -1, 0, $sformatf("vec%0d", i));

    // Burst of 4 with five full cycles ahead of byte 2: last push moves T13 -> T18.
    run_cmd(mk(R, 16'h0100, 8'd3, 8'h00, 4, 32'hC3C2C1C0, 4, 18, 4), 6, 5, "backpressure");

    // Two commands queued together: second pop right at the first's return to IDLE.
    p0 = push_t.size(); r0 = rden_t.size(); done = 1'b0;
    cmd_q.push_back(mk(W, 16'h0120, 8'd0, 8'h5E, 0, 0, 0, 0, 0).cmd);
    cmd_q.push_back(mk(R, 16'h0120, 8'd0, 8'h00, 0, 0, 0, 0, 0).cmd);
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (rden_t.size() >= r0 + 2 && cyc > rden_t[r0 + 1] + 1 && !bus.busy) done = 1'b1;
    end
    check("b2b completes", done, 1);
    if (done) begin
      check("b2b second pop T", rden_t[r0 + 1] - rden_t[r0], 4);
      check("b2b push count", push_t.size() - p0, 2);
      if (push_t.size() >= p0 + 2) begin
        check("b2b first byte", push_d[p0], K);
        check("b2b second byte", push_d[p0 + 1], 8'h5E);
        check("b2b pop after first push", rden_t[r0 + 1] > push_t[p0], 1);
      end
    end

    // Reset while waiting on the second byte of a 4-byte read.
    p0 = push_t.size(); r0 = rden_t.size(); t0 = -1;
    cmd_q.push_back(mk(R, 16'h0100, 8'd3, 8'h00, 0, 0, 0, 0, 0).cmd);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (t0 < 0 && rden_t.size() > r0) t0 = rden_t[r0];
      if (t0 >= 0 && cyc == t0 + 6) rst = 1'b1;
      if (t0 >= 0 && cyc == t0 + 8) rst = 1'b0;
      if (t0 >= 0 && cyc >= t0 + 16) break;
    end
    rst = 1'b0;
    check("midreset started", t0 >= 0, 1);
    check("midreset push count", push_t.size() - p0, 1);
    if (push_t.size() > p0) check("midreset byte", push_d[p0], 8'hC0);
    check("midreset busy", bus.busy, 0);
    run_cmd(vecs[13], -1, 0, "after reset");

    // Randomized stream against the reference memory.
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = 8'h00;
    p0 = push_t.size();
    for (int i = 0; i < 64; i++) begin
      cmd_packet_t c;
      int kind;
      c.data = 8'($urandom);
      c.len  = 8'($urandom_range(0, 7));
      if (i < 32) begin
        c.opcode = W; c.addr = 16'h0200 + 16'(i);
      end else begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: begin c.opcode = W; c.addr = 16'h0200 + 16'($urandom_range(0, 31)); end
          1: begin c.opcode = R; c.addr = 16'h0200 + 16'($urandom_range(0, 24)); end
          2: begin
            c.opcode = 8'($urandom);
            if (c.opcode == W || c.opcode == R) c.opcode = 8'h00;
            c.addr = 16'h0200;
          end
          default: begin
            c.opcode = ($urandom_range(0, 1) == 0) ? W : R;
            c.addr = 16'($urandom) | 16'h0400;
          end
        endcase
      end
      if (c.addr >= 16'h0400 || (c.opcode != W && c.opcode != R)) exp_q.push_back(E);
      else if (c.opcode == W) begin
        ref_mem[c.addr[9:0]] = c.data;
        exp_q.push_back(K);
      end else
        for (int j = 0; j <= int'(c.len); j++) exp_q.push_back(ref_mem[(int'(c.addr) + j) % 1024]);
      cmd_q.push_back(c);
    end
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk); #1;
      if (!bus.tx_fifo_wr_en && $urandom_range(0, 3) == 0) tx_full = 1'b1;
      else if ($urandom_range(0, 1) == 0) tx_full = 1'b0;
      if (head == cmd_q.size() && !bus.busy && !bus.cmd_fifo_rd_en && !fifo_valid) done = 1'b1;
    end
    tx_full = 1'b0;
    check("random completes", done, 1);
    check("random byte count", push_t.size() - p0, exp_q.size());
    for (int k = 0; k < exp_q.size() && p0 + k < push_t.size(); k++)
      check($sformatf("random byte %0d", k), push_d[p0 + k], exp_q[k]);
    check("no push while full", full_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
